// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the dual-master
// Wishbone arbiter.
package wb_arb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_M0,
    OWN_M1
  } owner_t;

endpackage

// File: rtl/wb_dual_master_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins,
// a tie goes to the master not served last.
module rr_arbiter2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       valid,
  output owner_t     pick
);

  // combinational pick
  always_comb begin
    valid = |req;
    pick  = OWN_M0;
    case (req)
      2'b01:   pick = OWN_M0;
      2'b10:   pick = OWN_M1;
      2'b11:   pick = (last_owner == OWN_M1) ? OWN_M0 : OWN_M1;
      default: pick = OWN_M0;
    endcase
  end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Shares one Wishbone slave port between two masters,
// one transfer per grant, optional registered response.
module wb_dual_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter bit REGISTER_RESP  = 1'b0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [WB_SEL_W-1:0]  m0_sel,
  input  logic [WB_DATA_W-1:0] m0_addr,
  input  logic [WB_DATA_W-1:0] m0_data_out,
  output logic [WB_DATA_W-1:0] m0_data_in,
  output logic                 m0_ack,
  output logic                 m0_err,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [WB_SEL_W-1:0]  m1_sel,
  input  logic [WB_DATA_W-1:0] m1_addr,
  input  logic [WB_DATA_W-1:0] m1_data_out,
  output logic [WB_DATA_W-1:0] m1_data_in,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [WB_SEL_W-1:0]  s_sel,
  output logic [WB_DATA_W-1:0] s_addr,
  output logic [WB_DATA_W-1:0] s_data_out,
  input  logic [WB_DATA_W-1:0] s_data_in,
  input  logic                 s_ack,
  output logic [1:0]           grant
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q, state_d;
  owner_t               owner_q, owner_d;
  owner_t               last_q;
  owner_t               rr_pick;
  logic                 rr_valid;
  logic [CNT_W-1:0]     cnt_q;
  logic [WB_DATA_W-1:0] resp_q;
  logic                 err_q;
  logic                 own_cyc;
  logic                 timeout;
  logic                 pass_ack;
  logic                 cap;
  logic                 to_err;
  logic                 busy;
  logic                 resp;
  logic                 ack_p;
  logic                 err_p;
  logic [WB_DATA_W-1:0] dout;
  logic [1:0]           req;

  assign req     = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign own_cyc = (owner_q == OWN_M1) ? m1_cyc : m0_cyc;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign busy    = (state_q == ST_BUSY);
  assign resp    = (state_q == ST_RESP);

  rr_arbiter2 u_rr (
    .req        (req),
    .last_owner (last_q),
    .valid      (rr_valid),
    .pick       (rr_pick)
  );

  // next-state and transfer-completion decode
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pass_ack = 1'b0;
    cap      = 1'b0;
    to_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d = ST_BUSY;
          owner_d = rr_pick;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
        end else if (s_ack) begin
          if (REGISTER_RESP) begin
            state_d = ST_RESP;
            cap     = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            pass_ack = 1'b1;
          end
        end else if (timeout) begin
          state_d = ST_RESP;
          to_err  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, ownership history, timeout counter, response capture
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_M0;
      last_q  <= OWN_M1;
      cnt_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (busy && state_d != ST_BUSY) last_q <= owner_q;
      if (!busy) cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      if (cap) begin
        resp_q <= s_data_in;
        err_q  <= 1'b0;
      end else if (to_err) begin
        resp_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  // slave request mux and master response steering
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_sel      = '0;
    s_addr     = '0;
    s_data_out = '0;
    if (busy) begin
      if (owner_q == OWN_M1) begin
        s_cyc      = m1_cyc;
        s_stb      = m1_stb;
        s_we       = m1_we;
        s_sel      = m1_sel;
        s_addr     = m1_addr;
        s_data_out = m1_data_out;
      end else begin
        s_cyc      = m0_cyc;
        s_stb      = m0_stb;
        s_we       = m0_we;
        s_sel      = m0_sel;
        s_addr     = m0_addr;
        s_data_out = m0_data_out;
      end
    end
    grant = 2'b00;
    if (busy || resp) grant = (owner_q == OWN_M1) ? 2'b10 : 2'b01;
    ack_p = REGISTER_RESP ? (resp & ~err_q) : pass_ack;
    err_p = resp & err_q;
    m0_ack = ack_p & (owner_q == OWN_M0);
    m1_ack = ack_p & (owner_q == OWN_M1);
    m0_err = err_p & (owner_q == OWN_M0);
    m1_err = err_p & (owner_q == OWN_M1);
    dout = REGISTER_RESP ? resp_q : (busy ? s_data_in : '0);
    m0_data_in = dout;
    m1_data_in = dout;
  end

endmodule
